// File: rtl/expr_seq_eval.sv
// Multi-cycle evaluator for the six-output expression set. A single shared
// WIDTH x WIDTH multiplier is time-multiplexed across four compute states.
module expr_seq_eval #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] Z,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output1,
  output logic [WIDTH-1:0] output2,
  output logic [WIDTH-1:0] output3,
  output logic [WIDTH-1:0] output4,
  output logic [WIDTH-1:0] output5,
  output logic [WIDTH-1:0] output6,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, C0, C1, C2, C3, DONE} state_t;

  state_t state;

  logic signed [WIDTH-1:0] x_r, y_r, z_r, p_r, q_r, r_r, s_r, t_r;
  logic signed [WIDTH-1:0] xy_r, pz_r, qr_r, px_r, xyp_r;
  logic signed [WIDTH-1:0] o1_r, o2_r, o3_r, o4_r, o5_r, o6_r;
  logic signed [WIDTH-1:0] mul_a, mul_b, mul_p;

  // Product wraps modulo 2^WIDTH; only the low half is ever consumed.
  function automatic logic signed [WIDTH-1:0] mul_wrap(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    mul_wrap = a * b;
  endfunction

  // Operand steering for the one shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      C0: begin
        mul_a = x_r;
        mul_b = y_r;
      end
      C1: begin
        mul_a = pz_r;
        mul_b = qr_r;
      end
      C2: begin
        mul_a = xy_r + q_r;
        mul_b = px_r;
      end
      C3: begin
        mul_a = xyp_r;
        mul_b = qr_r;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  assign mul_p = mul_wrap(mul_a, mul_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
      p_r   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      s_r   <= '0;
      t_r   <= '0;
      xy_r  <= '0;
      pz_r  <= '0;
      qr_r  <= '0;
      px_r  <= '0;
      xyp_r <= '0;
      o1_r  <= '0;
      o2_r  <= '0;
      o3_r  <= '0;
      o4_r  <= '0;
      o5_r  <= '0;
      o6_r  <= '0;
    end else begin
      case (state)
        // Accept stage: operands are frozen here for the whole evaluation.
        IDLE: begin
          if (in_valid) begin
            x_r   <= X;
            y_r   <= Y;
            z_r   <= Z;
            p_r   <= P;
            q_r   <= Q;
            r_r   <= R;
            s_r   <= S;
            t_r   <= T;
            state <= C0;
            busy  <= 1'b1;
          end
        end
        // C0: X*Y plus the shared sums reused by later products.
        C0: begin
          xy_r  <= mul_p;
          pz_r  <= p_r + z_r;
          qr_r  <= q_r - r_r;
          px_r  <= p_r + x_r;
          xyp_r <= x_r + y_r + p_r;
          state <= C1;
        end
        // C1: one product plus all the multiplier-free results.
        C1: begin
          o2_r  <= mul_p;
          o1_r  <= xy_r + pz_r;
          o3_r  <= x_r + y_r + s_r + t_r;
          o5_r  <= xy_r + p_r - (r_r + p_r + x_r);
          state <= C2;
        end
        // C2
        C2: begin
          o4_r  <= mul_p;
          state <= C3;
        end
        // C3: last product; results become visible next cycle.
        C3: begin
          o6_r      <= mul_p;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        // DONE: hold everything until the consumer takes it.
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Held low during reset so nothing is taken while the block is cleared.
  assign in_ready = (state == IDLE) && !rst;

  assign output1 = o1_r;
  assign output2 = o2_r;
  assign output3 = o3_r;
  assign output4 = o4_r;
  assign output5 = o5_r;
  assign output6 = o6_r;

endmodule

// File: tb/tb_expr_seq_eval.sv
// Randomized self-checking bench for expr_seq_eval against a plain-arithmetic model.
module tb_expr_seq_eval;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [31:0] X, Y, Z, P, Q, R, S, T;
  logic [31:0] output1, output2, output3, output4, output5, output6;

  logic [31:0] ops [8];
  logic [31:0] expv[6];
  logic [31:0] expa[6];
  int n_chk = 0;
  int n_fail = 0;

  assign X = ops[0];
  assign Y = ops[1];
  assign Z = ops[2];
  assign P = ops[3];
  assign Q = ops[4];
  assign R = ops[5];
  assign S = ops[6];
  assign T = ops[7];

  expr_seq_eval #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .Z(Z), .P(P), .Q(Q), .R(R), .S(S), .T(T),
    .out_valid(out_valid), .out_ready(out_ready),
    .output1(output1), .output2(output2), .output3(output3),
    .output4(output4), .output5(output5), .output6(output6),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the formulas, all in 32-bit arithmetic.
  task automatic model();
    logic [31:0] x, y, z, p, q, r, s, t;
    x = ops[0]; y = ops[1]; z = ops[2]; p = ops[3];
    q = ops[4]; r = ops[5]; s = ops[6]; t = ops[7];
    expv[0] = x * y + (z + p);
    expv[1] = (p + z) * (q - r);
    expv[2] = x + y + s + t;
    expv[3] = (x * y + q) * (p + x);
    expv[4] = x * y + p - (r + p + x);
    expv[5] = (x + y + p) * (q - r);
  endtask

  function automatic logic [31:0] dut_out(input int i);
    case (i)
      0: return output1;
      1: return output2;
      2: return output3;
      3: return output4;
      4: return output5;
      default: return output6;
    endcase
  endfunction

  task automatic cmp_all(input string tag);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_out%0d", tag, i + 1), dut_out(i), expv[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    if (!in_ready) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  task automatic set_ops(input logic [31:0] a, b, c, d, e, f, g, h);
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
    ops[4] = e; ops[5] = f; ops[6] = g; ops[7] = h;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One full transaction: accept, measure latency, stall, compare, release.
  task automatic do_txn(input string tag, input int stall, input bit stable_chk);
    int lat;
    model();
    wait_ready(tag);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    cmp_all(tag);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (stable_chk) begin
        chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_stall_out1"}, output1, expv[0]);
        chk({tag, "_stall_out6"}, output6, expv[5]);
      end
    end
    if (stall > 0 && !stable_chk) cmp_all({tag, "_post_stall"});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_clear"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_hold_out4"}, output4, expv[3]);
  endtask

  initial begin
    set_ops(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out1", output1, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    set_ops(2, 3, 4, 5, 10, 7, 1, 1);
    model();
    chk("basic_model_o5", expv[4], 32'hFFFF_FFFD);
    do_txn("basic", 0, 1'b0);

    set_ops(32'h0001_0000, 32'h0001_0000, 0, 0, 0, 0, 0, 0);
    do_txn("ovf", 0, 1'b0);

    set_ops(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'h3333_3333,
            32'h5555_5555, 32'hAAAA_AAAA, 32'h0000_0001, 32'hFFFF_FFFF);
    do_txn("bp", 10, 1'b1);

    // Back-to-back: in_valid held high across the DONE handshake.
    begin
      int n;
      bit got_a, acc;
      set_ops(11, 13, 17, 19, 23, 29, 31, 37);
      model();
      for (int i = 0; i < 6; i++) expa[i] = expv[i];
      out_ready = 1'b1;
      in_valid = 1'b1;
      wait_ready("b2b");
      tick();
      set_ops(32'hDEAD_BEEF, 32'hCAFE_F00D, 5, 32'hFFFF_FFF0, 9, 100, 3, 4);
      model();
      n = 0;
      got_a = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (out_valid && !got_a) begin
          for (int j = 0; j < 6; j++)
            chk($sformatf("b2b_a_out%0d", j + 1), dut_out(j), expa[j]);
          got_a = 1'b1;
        end
        acc = in_ready;
        tick();
        n++;
        if (acc) break;
      end
      chk("b2b_a_seen", 32'(got_a), 32'd1);
      chk("b2b_gap", 32'(n), 32'd6);
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      chk("b2b_b_valid", 32'(out_valid), 32'd1);
      cmp_all("b2b_b");
      tick();
      out_ready = 1'b0;
      chk("b2b_done", 32'(out_valid), 32'd0);
    end

    // Abort in C2: accept edge -> C0, +1 edge C1, +1 edge C2.
    set_ops(1000, 2000, 3000, 4000, 5000, 6000, 7000, 8000);
    wait_ready("abort");
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_out1", output1, 32'd0);
    chk("abort_out2", output2, 32'd0);
    chk("abort_out3", output3, 32'd0);
    chk("abort_out5", output5, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_rel_ready", 32'(in_ready), 32'd1);
    set_ops(7, 6, 5, 4, 3, 2, 1, 0);
    do_txn("after_abort", 0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      set_ops(rnd_val(), rnd_val(), rnd_val(), rnd_val(),
              rnd_val(), rnd_val(), rnd_val(), rnd_val());
      do_txn("rnd", ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
